mole_game_ctrl: RTL and testbench
=================================

// Module: mole_game_ctrl
// PURPOSE
//  Game sequencer for whack-a-mole; drives vga_display's mole_position/score/guess_correct/guess_wrong.
//  Picks pseudo-random slots, times mole exposure, judges button presses, counts rounds and score.
//  Sits between the debounced button front-end and vga_display, in the clk_pixel domain.
// PARAMETERS
//  TICK_DIV     25000  clk_pixel cycles per game tick (1 ms at 25 MHz)
//  MOLE_TICKS   1000   ticks a mole stays up before a miss
//  FLASH_TICKS  300    ticks guess_correct/guess_wrong stay high
//  ROUNDS       20     moles per game
//  MIN_TICKS    250    MOLE_TICKS floor (SPEEDUP_EN only)
// PORTS
//  clk_pixel     in   1  25 MHz pixel clock, sole clock
//  rst           in   1  asynchronous reset, active-high
//  start         in   1  1-cycle pulse; starts a game from IDLE/OVER
//  btn           in   5  1-cycle debounced presses; bit0 top,1 left,2 center,3 right,4 bot
//  mole_position out  3  slot index 0..4 (same encoding as btn); never >4
//  mole_visible  out  1  high in SHOW only
//  score         out  8  hits this game, saturates at 255
//  guess_correct out  1  level, high during HIT
//  guess_wrong   out  1  level, high during MISS
//  game_over     out  1  high in OVER
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, prescaler 0, LFSR 8'hA5, round count 0.
//  Prescaler: free-running 0..TICK_DIV-1; tick = 1 cycle pulse at TICK_DIV-1.
//  Timer: loaded with N on state entry, decremented on tick; exit on tick where timer==1 (N ticks).
//  FSM (all transitions registered, outputs registered -> 1-cycle latency from cause):
//   IDLE : start -> SPAWN; score<=0, rounds<=0.
//   SPAWN: 1 cycle; pos=LFSR%5; if pos==prev pos use (pos+1)%5; -> SHOW, timer=MOLE_TICKS.
//   SHOW : btn==one-hot matching mole_position -> HIT, score+1 (sat 255).
//          btn!=0 otherwise (wrong slot or >1 bit set) -> MISS.
//          timer expiry with btn==0 -> MISS. press and expiry same cycle: press is judged.
//   HIT/MISS: timer=FLASH_TICKS; btn ignored; on expiry rounds+1;
//          rounds==ROUNDS-1 -> OVER else SPAWN.
//   OVER : outputs hold final score; start -> SPAWN with score/rounds cleared (as IDLE).
//  start outside IDLE/OVER ignored. LFSR x^8+x^6+x^5+x^4+1 steps every cycle (press timing seeds).
//  mole_position holds last slot outside SHOW; vga_display always indexes a valid slot.
//  rst mid-game: immediate return to reset state, no flash completes.
// CONFIGURATION
//  SPEEDUP_EN defined: SHOW load value = max(MIN_TICKS, MOLE_TICKS - 50*(score>>2)).
//  SPEEDUP_EN undefined: SHOW load value always MOLE_TICKS; MIN_TICKS unused.
// STRUCTURE
//  mole_game_pkg: state encoding (IDLE,SPAWN,SHOW,HIT,MISS,OVER), slot constants SLOT_TOP..SLOT_BOT,
//   NUM_SLOTS=5, LFSR seed/taps.
//  Sub-module mole_lfsr: 8-bit Galois LFSR, async rst to seed, outputs slot 0..4.
//  Prescaler, timer, FSM, score/round counters in mole_game_ctrl.
// TESTING (TICK_DIV=4, MOLE_TICKS=3, FLASH_TICKS=2, ROUNDS=4)
//  rst high 3 cycles -> all outputs 0, no start -> stays IDLE indefinitely.
//  start, press btn=1<<mole_position in SHOW -> next cycle guess_correct=1, score=1; high 8 cycles.
//  start, no press -> SHOW lasts 12 cycles (+/-3), then guess_wrong=1, score=0.
//  SHOW with btn=5'b00011 incl. correct bit -> guess_wrong=1; press on expiry cycle correct -> HIT.
//  4 rounds all hit -> game_over=1, score=4; start -> score 0, SPAWN; rst in SHOW -> IDLE next edge.
//  SPEEDUP_EN, MOLE_TICKS=400,MIN_TICKS=250, score 8 -> SHOW 300 ticks; score 20 -> 250 ticks.

Source files
------------

// File: rtl/mole_game_pkg.sv
// Shared encodings for the whack-a-mole sequencer: FSM states, slot indices, LFSR seed/taps.
package mole_game_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SPAWN = 3'd1;
  localparam state_t ST_SHOW  = 3'd2;
  localparam state_t ST_HIT   = 3'd3;
  localparam state_t ST_MISS  = 3'd4;
  localparam state_t ST_OVER  = 3'd5;

  localparam logic [2:0] SLOT_TOP    = 3'd0;
  localparam logic [2:0] SLOT_LEFT   = 3'd1;
  localparam logic [2:0] SLOT_CENTER = 3'd2;
  localparam logic [2:0] SLOT_RIGHT  = 3'd3;
  localparam logic [2:0] SLOT_BOT    = 3'd4;
  localparam int         NUM_SLOTS   = 5;

  // Galois right-shift mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int TIMER_W = 16;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic logic [2:0] slot_next(input logic [2:0] s);
    return (s == SLOT_BOT) ? SLOT_TOP : s + 3'd1;
  endfunction

  function automatic logic [4:0] slot_onehot(input logic [2:0] s);
    return 5'd1 << s;
  endfunction

endpackage

// File: rtl/mole_game_ctrl_lfsr.sv
// 8-bit Galois LFSR stepping every clk_pixel cycle; exposes the current value reduced to a slot 0..4.
module mole_lfsr
  import mole_game_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       rst,
  output logic [2:0] slot
);

  logic [7:0] lfsr_r;

  // Free-running sequence; button timing decides which value gets sampled
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  always_comb begin
    slot = 3'(lfsr_r % 8'(NUM_SLOTS));
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: tick prescaler, state timer, FSM, score and round counters.
// Optional build macro SPEEDUP_EN shortens mole exposure as the score rises.
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int TICK_DIV    = 25000,
  parameter int MOLE_TICKS  = 1000,
  parameter int FLASH_TICKS = 300,
  parameter int ROUNDS      = 20
`ifdef SPEEDUP_EN
  , parameter int MIN_TICKS = 250
`endif
) (
  input  logic       clk_pixel,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] btn,
  output logic [2:0] mole_position,
  output logic       mole_visible,
  output logic [7:0] score,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic       game_over
);

  localparam int PRESC_W = $clog2(TICK_DIV + 1);

  logic [PRESC_W-1:0] presc_r;
  logic               tick_s;
  logic [2:0]         slot_s;
  logic [2:0]         spawn_pos_s;
  state_t             state_r, state_nxt_s;
  logic [TIMER_W-1:0] timer_r, timer_nxt_s, show_load_s;
  logic [7:0]         score_nxt_s;
  logic [7:0]         rounds_r, rounds_nxt_s;
  logic [2:0]         pos_nxt_s;

  mole_lfsr u_lfsr (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .slot      (slot_s)
  );

  assign tick_s = (presc_r == PRESC_W'(TICK_DIV - 1));

  // Game tick prescaler
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      presc_r <= {PRESC_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PRESC_W{1'b0}};
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

`ifdef SPEEDUP_EN
  logic [31:0] speed_dec_s;

  // Exposure shrinks by 50 ticks per 4 points, floored at MIN_TICKS
  always_comb begin
    speed_dec_s = 32'd50 * {26'd0, score[7:2]};
    if (32'(MOLE_TICKS) > 32'(MIN_TICKS) + speed_dec_s) begin
      show_load_s = TIMER_W'(32'(MOLE_TICKS) - speed_dec_s);
    end else begin
      show_load_s = TIMER_W'(MIN_TICKS);
    end
  end
`else
  always_comb begin
    show_load_s = TIMER_W'(MOLE_TICKS);
  end
`endif

  // Next-state, timer and counter decisions
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r;
    score_nxt_s  = score;
    rounds_nxt_s = rounds_r;
    pos_nxt_s    = mole_position;
    spawn_pos_s  = slot_s;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_nxt_s  = ST_SPAWN;
          score_nxt_s  = 8'd0;
          rounds_nxt_s = 8'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SPAWN: begin
        if (slot_s == mole_position) begin
          spawn_pos_s = slot_next(slot_s);
        end else begin
          spawn_pos_s = slot_s;
        end
        pos_nxt_s   = spawn_pos_s;
        state_nxt_s = ST_SHOW;
        timer_nxt_s = show_load_s;
      end
      ST_SHOW: begin
        // A press always wins over a same-cycle expiry
        if (btn != 5'd0) begin
          timer_nxt_s = TIMER_W'(FLASH_TICKS);
          if (btn == slot_onehot(mole_position)) begin
            state_nxt_s = ST_HIT;
            score_nxt_s = (score == 8'hFF) ? 8'hFF : score + 8'd1;
          end else begin
            state_nxt_s = ST_MISS;
          end
        end else if (tick_s) begin
          if (timer_r == TIMER_W'(1)) begin
            state_nxt_s = ST_MISS;
            timer_nxt_s = TIMER_W'(FLASH_TICKS);
          end else begin
            timer_nxt_s = timer_r - TIMER_W'(1);
          end
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      ST_HIT, ST_MISS: begin
        if (tick_s) begin
          if (timer_r == TIMER_W'(1)) begin
            rounds_nxt_s = rounds_r + 8'd1;
            timer_nxt_s  = {TIMER_W{1'b0}};
            if (rounds_r == 8'(ROUNDS - 1)) begin
              state_nxt_s = ST_OVER;
            end else begin
              state_nxt_s = ST_SPAWN;
            end
          end else begin
            timer_nxt_s = timer_r - TIMER_W'(1);
          end
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TIMER_W{1'b0}};
      rounds_r      <= 8'd0;
      score         <= 8'd0;
      mole_position <= 3'd0;
      mole_visible  <= 1'b0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      rounds_r      <= rounds_nxt_s;
      score         <= score_nxt_s;
      mole_position <= pos_nxt_s;
      mole_visible  <= (state_nxt_s == ST_SHOW);
      guess_correct <= (state_nxt_s == ST_HIT);
      guess_wrong   <= (state_nxt_s == ST_MISS);
      game_over     <= (state_nxt_s == ST_OVER);
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: directed vector table, corner sequences, random play vs model.
module tb_mole_game_ctrl;

  localparam int TD = 4;
  localparam int MT = 3;
  localparam int FT = 2;
  localparam int RN = 4;

  logic       clk_pixel = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] btn = 5'd0;
  logic [2:0] mole_position;
  logic       mole_visible;
  logic [7:0] score;
  logic       guess_correct;
  logic       guess_wrong;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  mole_game_ctrl #(.TICK_DIV(TD), .MOLE_TICKS(MT), .FLASH_TICKS(FT), .ROUNDS(RN)) dut (
    .clk_pixel     (clk_pixel),
    .rst           (rst),
    .start         (start),
    .btn           (btn),
    .mole_position (mole_position),
    .mole_visible  (mole_visible),
    .score         (score),
    .guess_correct (guess_correct),
    .guess_wrong   (guess_wrong),
    .game_over     (game_over)
  );

  always #5 clk_pixel = ~clk_pixel;

  // ---------------- reference model (game rules, one update per clock edge) ----------------
  typedef enum int {M_IDLE, M_SPAWN, M_SHOW, M_HIT, M_MISS, M_OVER} mode_e;
  mode_e      m_mode;
  int         m_presc, m_ticks, m_limit, m_score, m_rounds, m_pos;
  logic [7:0] m_lfsr;

  function automatic int show_limit(input int sc);
`ifdef SPEEDUP_EN
    int v;
    v = MT - 50 * (sc / 4);
    return (v > 250) ? v : 250;
`else
    return MT + 0 * sc;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_presc = 0; m_ticks = 0; m_limit = 0;
    m_score = 0; m_rounds = 0; m_pos = 0; m_lfsr = 8'hA5;
  endtask

  task automatic model_clock(input bit st, input bit [4:0] b);
    bit tick;
    int slot;
    tick = (m_presc == TD - 1);
    slot = int'(m_lfsr) % 5;
    case (m_mode)
      M_IDLE, M_OVER: if (st) begin m_mode = M_SPAWN; m_score = 0; m_rounds = 0; end
      M_SPAWN: begin
        m_pos = (slot == m_pos) ? (slot + 1) % 5 : slot;
        m_limit = show_limit(m_score); m_ticks = 0; m_mode = M_SHOW;
      end
      M_SHOW: begin
        if (b != 5'd0) begin
          m_ticks = 0;
          if (b == (5'd1 << m_pos)) begin
            m_mode = M_HIT;
            if (m_score < 255) m_score++;
          end else m_mode = M_MISS;
        end else if (tick) begin
          m_ticks++;
          if (m_ticks == m_limit) begin m_mode = M_MISS; m_ticks = 0; end
        end
      end
      default: begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == FT) begin
            m_rounds++; m_ticks = 0;
            m_mode = (m_rounds == RN) ? M_OVER : M_SPAWN;
          end
        end
      end
    endcase
    m_presc = (m_presc + 1) % TD;
    m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  endtask

  function automatic logic [15:0] dut_vec();
    return {mole_position, mole_visible, score, guess_correct, guess_wrong, game_over};
  endfunction

  function automatic logic [15:0] model_vec();
    return {3'(m_pos), m_mode == M_SHOW, 8'(m_score), m_mode == M_HIT, m_mode == M_MISS, m_mode == M_OVER};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Called just after a negedge; applies inputs across one posedge and compares at the next negedge
  task automatic step(input bit st, input bit [4:0] b);
    start = st; btn = b;
    @(posedge clk_pixel);
    model_clock(st, b);
    @(negedge clk_pixel);
    start = 1'b0; btn = 5'd0;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    repeat (n) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("reset_zero", dut_vec(), 16'h0000);
    rst = 1'b0;
  endtask

  task automatic wait_mode(input mode_e target, input int budget);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin step(1'b0, 5'd0); n++; end
    n_cmp++;
    if (m_mode != target) begin
      n_bad++;
      $display("FAIL wait_mode: mode %0d never reached %0d within %0d cycles", m_mode, target, budget);
    end
  endtask

  task automatic finish_flash();
    int n;
    n = 0;
    while ((m_mode == M_HIT || m_mode == M_MISS) && n < 40) begin step(1'b0, 5'd0); n++; end
  endtask

  task automatic ensure_game();
    if (m_mode == M_IDLE || m_mode == M_OVER) step(1'b1, 5'd0);
  endtask

  typedef struct { bit use_correct; bit add_other; int delay; bit exp_hit; } vec_t;
  vec_t vecs[6];

  initial begin
    int n, d, p;
    bit [4:0] b;
    vecs[0] = '{1'b1, 1'b0, 0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 3, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 7, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 4, 1'b0};

    @(negedge clk_pixel);
    do_reset(3);
    repeat (20) step(1'b0, 5'd0);
    check("idle_hold", dut_vec(), 16'h0000);

    // No press: SHOW lasts 3 ticks of 4 cycles, phase dependent
    step(1'b1, 5'd0);
    wait_mode(M_SHOW, 10);
    n = 0;
    while (mole_visible && n < 40) begin n++; step(1'b0, 5'd0); end
    check_range("show_len", n, 9, 12);
    check("timeout_miss", {8'd0, score, guess_wrong, guess_correct}, {8'd0, 8'd0, 1'b1, 1'b0});

    // Correct press: next cycle HIT with score 1, flash lasts 2 ticks
    finish_flash();
    wait_mode(M_SHOW, 20);
    p = m_pos;
    step(1'b0, 5'(5'd1 << p));
    check("hit_now", {8'd0, score, guess_correct, guess_wrong}, {8'd0, 8'd1, 1'b1, 1'b0});
    n = 0;
    while (guess_correct && n < 40) begin n++; step(1'b0, 5'd0); end
    check_range("hit_len", n, 5, 8);

    // Press on the very cycle the timer expires is still judged
    wait_mode(M_SHOW, 20);
    n = 0;
    while (!(m_ticks == MT - 1 && m_presc == TD - 1) && n < 40) begin step(1'b0, 5'd0); n++; end
    p = m_pos;
    step(1'b0, 5'(5'd1 << p));
    check("expiry_press", {14'd0, guess_correct, guess_wrong}, 16'h0002);
    finish_flash();

    // Vector table
    foreach (vecs[i]) begin
      ensure_game();
      wait_mode(M_SHOW, 20);
      for (d = 0; d < vecs[i].delay; d++) step(1'b0, 5'd0);
      b = 5'd0;
      if (vecs[i].use_correct) b = b | 5'(5'd1 << m_pos);
      if (vecs[i].add_other) b = b | 5'(5'd1 << ((m_pos + 1) % 5));
      step(1'b0, b);
      check($sformatf("vec%0d", i), {14'd0, guess_correct, guess_wrong},
            vecs[i].exp_hit ? 16'h0002 : 16'h0001);
      finish_flash();
    end

    // Full game, all hits
    do_reset(3);
    step(1'b1, 5'd0);
    for (int r = 0; r < RN; r++) begin
      wait_mode(M_SHOW, 20);
      p = m_pos;
      step(1'b0, 5'(5'd1 << p));
      finish_flash();
    end
    check("game_over", {7'd0, game_over, score}, {7'd0, 1'b1, 8'd4});
    step(1'b1, 5'd0);
    check("restart", {6'd0, game_over, mole_visible, score}, 16'h0000);

    // Asynchronous reset in SHOW clears everything at once
    wait_mode(M_SHOW, 10);
    #2 rst = 1'b1;
    #1 check("rst_in_show", dut_vec(), 16'h0000);
    model_reset();
    @(negedge clk_pixel);
    rst = 1'b0;

    // Random play
    for (int k = 0; k < 3000; k++) begin
      n = $urandom_range(0, 99);
      if (n < 6) b = 5'(5'd1 << m_pos);
      else if (n < 10) b = 5'($urandom_range(1, 31));
      else b = 5'd0;
      step($urandom_range(0, 99) < 4, b);
      if ($urandom_range(0, 999) == 0) do_reset(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
